rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Controller for the RV32E register array's single write port.
- Arbitrates writebacks from the EXU and the LSU onto that port using round-robin.
- Keeps a per-register busy scoreboard. Issue is blocked on RAW/WAW hazards until the producing write has reached the array.
- Sits between the decode/issue stage, the two result producers, and the register array's wen/write_rd/write_data inputs.

Parameters:
- DATA_W, 32, width of write data.
- REG_NUM, 16, number of architectural registers.
- IDX_W, 4, log2(REG_NUM). Register indices use only the low IDX_W bits of every 5-bit address; upper bits are ignored.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- issue_valid  input  1  decode presents an instruction.
- issue_rs1  input  5  source register 1.
- issue_rs2  input  5  source register 2.
- issue_rd  input  5  destination register (0 = no destination).
- issue_ready  output  1  instruction may issue this cycle.
- exu_wb_valid  input  1  EXU result pending.
- exu_wb_rd  input  5  EXU destination.
- exu_wb_data  input  DATA_W  EXU result.
- exu_wb_ready  output  1  EXU result accepted this cycle.
- lsu_wb_valid  input  1  LSU result pending.
- lsu_wb_rd  input  5  LSU destination.
- lsu_wb_data  input  DATA_W  LSU result.
- lsu_wb_ready  output  1  LSU result accepted this cycle.
- flush  input  1  clear the scoreboard (pipeline redirect).
- rf_wen  output  1  write enable to the register array.
- rf_waddr  output  5  write index to the register array.
- rf_wdata  output  DATA_W  write data to the register array.
- wb_err  output  1  sticky: a writeback targeted a non-busy register.

Behaviour:
- Reset:
  - busy[] = 0; rr_last = LSU, so EXU wins the first tie.
  - rf_wen = 0, rf_waddr = 0, rf_wdata = 0, wb_err = 0.
  - While rst = 1: issue_ready, exu_wb_ready and lsu_wb_ready are 0.
  - Reset mid-operation discards any in-flight accepted writeback; no rf_wen pulse follows.
- Scoreboard:
  - busy[0] is constant 0.
  - Index 0 as a source never stalls; index 0 as a destination never sets busy.
- issue_ready (combinational) = !busy[rs1] && !busy[rs2] && !busy[rd] && !flush && !rst.
- Issue fire = issue_valid && issue_ready. On fire with rd != 0, busy[rd] is set at the next edge.
- Arbitration (combinational grant):
  - Only one valid: that source is granted.
  - Both valid: the source other than rr_last is granted, and rr_last updates to the winner.
  - The granted source's ready = 1; the loser's ready = 0 and it must hold valid/rd/data stable.
- Accept = granted valid. At the next edge: rf_wen = 1 if rd != 0, else 0; rf_waddr = rd; rf_wdata = data.
  - Registered, one-cycle latency.
  - rf_wen is deasserted in any cycle following no accept.
- Accepted rd = 0: the writeback is consumed and dropped (rf_wen = 0); busy and wb_err are unaffected.
- Busy clear:
  - When rf_wen = 1 at an edge, busy[rf_waddr] clears at that same edge (the array write edge).
  - Consequence: a dependent instruction issues no earlier than the cycle after the array holds the value. There is no bypass.
- Collisions:
  - A set and a clear on the same index in the same edge cannot occur legally, because busy blocks issue.
  - If it does occur, the set wins.
- wb_err: set at the accept edge when rd != 0 and busy[rd] = 0. Only rst clears it.
- flush: at the next edge, all busy bits clear. Already-accepted writebacks still drive rf_wen, and their clear is a no-op.
- Throughput: one writeback per cycle sustained. With both sources continuously valid, grants alternate EXU, LSU, EXU, and so on.

Test Plan:
- Reset, then issue rd=5 at cycle 1; EXU wb rd=5 data=0xDEADBEEF at cycle 3 -> rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle 4; issue_ready for rs1=5 low in cycles 2-4, high in cycle 5.
- busy[3], busy[7] set; EXU(rd=3,0x11) and LSU(rd=7,0x22) valid together for 2 cycles from reset -> cycle 1 exu_wb_ready=1, lsu_wb_ready=0; cycle 2 LSU granted; rf writes 3<-0x11 then 7<-0x22 on consecutive cycles.
- Issue rd=0 and rs1=0 repeatedly -> issue_ready stays 1, busy stays all-zero; EXU wb rd=0 accepted with rf_wen=0 and wb_err=0.
- LSU wb rd=9 with busy[9]=0 -> write still performed (rf_waddr=9), wb_err=1 from the next cycle until rst.
- busy[2], busy[4] set; assert flush for one cycle -> issue_ready=0 that cycle, busy all zero next cycle, and issue with rs1=2, rd=4 fires immediately.
- Assert rst the cycle after EXU wb rd=6 is accepted -> no rf_wen pulse, busy[6]=0, all readies 0 during reset and rf_wen=0 after release.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// Round-robin EXU/LSU writeback arbiter and busy scoreboard for the RV32E register array write port.
// Write reaches the array one cycle after accept; the losing producer is held off through its ready.
module rf_wb_scheduler #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 16,
    parameter int IDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              issue_valid,
    input  logic [4:0]        issue_rs1,
    input  logic [4:0]        issue_rs2,
    input  logic [4:0]        issue_rd,
    output logic              issue_ready,

    input  logic              exu_wb_valid,
    input  logic [4:0]        exu_wb_rd,
    input  logic [DATA_W-1:0] exu_wb_data,
    output logic              exu_wb_ready,

    input  logic              lsu_wb_valid,
    input  logic [4:0]        lsu_wb_rd,
    input  logic [DATA_W-1:0] lsu_wb_data,
    output logic              lsu_wb_ready,

    input  logic              flush,

    output logic              rf_wen,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_err
);

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] dat;
    } wb_t;

    localparam logic SRC_EXU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    logic [REG_NUM-1:0] r_busy;
    logic               r_rr_last;
    logic               r_wen;
    logic [4:0]         r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_err;

    logic [IDX_W-1:0]   w_rs1_idx;
    logic [IDX_W-1:0]   w_rs2_idx;
    logic [IDX_W-1:0]   w_rd_idx;
    logic               w_rs1_busy;
    logic               w_rs2_busy;
    logic               w_rd_busy;
    logic               w_issue_fire;

    logic               w_both_vld;
    logic               w_gnt_exu;
    logic               w_gnt_lsu;
    logic               w_acc;
    wb_t                w_acc_wb;
    logic [IDX_W-1:0]   w_acc_idx;
    logic               w_acc_has_rd;

    logic [REG_NUM-1:0] w_busy_nxt;
    logic               w_unused_hi_bits;

    assign w_rs1_idx = issue_rs1[IDX_W-1:0];
    assign w_rs2_idx = issue_rs2[IDX_W-1:0];
    assign w_rd_idx  = issue_rd[IDX_W-1:0];

    // Index 0 is hard-wired non-busy regardless of the stored bit.
    assign w_rs1_busy = (w_rs1_idx != '0) && r_busy[w_rs1_idx];
    assign w_rs2_busy = (w_rs2_idx != '0) && r_busy[w_rs2_idx];
    assign w_rd_busy  = (w_rd_idx  != '0) && r_busy[w_rd_idx];

    assign issue_ready  = !w_rs1_busy && !w_rs2_busy && !w_rd_busy && !flush && !rst;
    assign w_issue_fire = issue_valid && issue_ready;

    assign w_both_vld = exu_wb_valid && lsu_wb_valid;
    assign w_gnt_exu  = !rst && exu_wb_valid && (!lsu_wb_valid || (r_rr_last == SRC_LSU));
    assign w_gnt_lsu  = !rst && lsu_wb_valid && (!exu_wb_valid || (r_rr_last == SRC_EXU));
    assign w_acc      = w_gnt_exu || w_gnt_lsu;

    assign exu_wb_ready = w_gnt_exu;
    assign lsu_wb_ready = w_gnt_lsu;

    always_comb begin
        w_acc_wb = '0;
        if (w_gnt_exu) begin
            w_acc_wb.rd  = exu_wb_rd;
            w_acc_wb.dat = exu_wb_data;
        end else if (w_gnt_lsu) begin
            w_acc_wb.rd  = lsu_wb_rd;
            w_acc_wb.dat = lsu_wb_data;
        end
    end

    assign w_acc_idx    = w_acc_wb.rd[IDX_W-1:0];
    assign w_acc_has_rd = (w_acc_idx != '0);

    // Clear from the array write first, then the issue set so a set wins on a collision.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else if (r_wen) begin
            w_busy_nxt[r_waddr[IDX_W-1:0]] = 1'b0;
        end
        if (w_issue_fire && (w_rd_idx != '0)) begin
            w_busy_nxt[w_rd_idx] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            r_rr_last <= SRC_LSU;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_both_vld) begin
                r_rr_last <= w_gnt_exu ? SRC_EXU : SRC_LSU;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_wen <= w_acc && w_acc_has_rd;
            if (w_acc) begin
                r_waddr <= w_acc_wb.rd;
                r_wdata <= w_acc_wb.dat;
                if (w_acc_has_rd && !r_busy[w_acc_idx]) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Masking with rst keeps a write accepted just before reset from reaching the array.
    assign rf_wen   = r_wen && !rst;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign wb_err   = r_err;

    assign w_unused_hi_bits = ^{issue_rs1[4:IDX_W], issue_rs2[4:IDX_W], issue_rd[4:IDX_W]};

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Randomized and directed bench for rf_wb_scheduler against a behavioural scoreboard model.
module tb_rf_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_ready;
    logic        exu_wb_valid;
    logic [4:0]  exu_wb_rd;
    logic [31:0] exu_wb_data;
    logic        exu_wb_ready;
    logic        lsu_wb_valid;
    logic [4:0]  lsu_wb_rd;
    logic [31:0] lsu_wb_data;
    logic        lsu_wb_ready;
    logic        flush;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_err;

    always #5 clk = ~clk;

    rf_wb_scheduler #(.DATA_W(32), .REG_NUM(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_ready(issue_ready),
        .exu_wb_valid(exu_wb_valid), .exu_wb_rd(exu_wb_rd), .exu_wb_data(exu_wb_data),
        .exu_wb_ready(exu_wb_ready),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
        .lsu_wb_ready(lsu_wb_ready),
        .flush(flush),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_err(wb_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: set of busy registers, who won the last contention, the write due at the array next, sticky error.
    logic [15:0] m_busy;
    bit          m_last_exu;
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;
    bit          m_valid = 0;
    bit          last_ge, last_gl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit reg_busy(input logic [4:0] r);
        return (r[3:0] != 4'd0) && m_busy[r[3:0]];
    endfunction

    function automatic bit exp_issue_ready();
        return !rst && !flush && !reg_busy(issue_rs1) && !reg_busy(issue_rs2) && !reg_busy(issue_rd);
    endfunction

    task automatic exp_grant(output bit ge, output bit gl);
        ge = 0;
        gl = 0;
        if (!rst) begin
            if (exu_wb_valid && lsu_wb_valid) begin
                if (m_last_exu) gl = 1; else ge = 1;
            end else if (exu_wb_valid) begin
                ge = 1;
            end else if (lsu_wb_valid) begin
                gl = 1;
            end
        end
    endtask

    task automatic model_update(input bit ge, input bit gl);
        logic [15:0] nb;
        logic [4:0]  rd;
        bit          fire;
        fire = issue_valid && exp_issue_ready();
        if (rst) begin
            m_busy = '0; m_last_exu = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_err = 0;
            m_valid = 1;
        end else begin
            nb = m_busy;
            if (flush) nb = '0;
            else if (m_wen) nb[m_waddr[3:0]] = 1'b0;
            if (fire && issue_rd[3:0] != 4'd0) nb[issue_rd[3:0]] = 1'b1;
            if (ge || gl) begin
                rd = ge ? exu_wb_rd : lsu_wb_rd;
                if (rd[3:0] != 4'd0 && !m_busy[rd[3:0]]) m_err = 1;
                m_wen   = (rd[3:0] != 4'd0);
                m_waddr = rd;
                m_wdata = ge ? exu_wb_data : lsu_wb_data;
            end else begin
                m_wen = 0;
            end
            if (exu_wb_valid && lsu_wb_valid) m_last_exu = ge;
            nb[0] = 1'b0;
            m_busy = nb;
        end
    endtask

    // Called at a negedge with inputs already driven; compares, crosses one posedge, advances the model.
    task automatic step();
        bit ge, gl;
        #1;
        exp_grant(ge, gl);
        if (m_valid) begin
            chk("issue_ready", issue_ready, exp_issue_ready());
            chk("exu_wb_ready", exu_wb_ready, ge);
            chk("lsu_wb_ready", lsu_wb_ready, gl);
            chk("rf_wen", rf_wen, m_wen && !rst);
            chk("wb_err", wb_err, m_err);
            if (m_wen && !rst) begin
                chk("rf_waddr", rf_waddr, m_waddr);
                chk("rf_wdata", rf_wdata, m_wdata);
            end
        end
        last_ge = ge;
        last_gl = gl;
        @(posedge clk);
        model_update(ge, gl);
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
        exu_wb_valid = 0; exu_wb_rd = '0; exu_wb_data = '0;
        lsu_wb_valid = 0; lsu_wb_rd = '0; lsu_wb_data = '0;
        flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    function automatic logic [4:0] pick_rd();
        logic [4:0] r;
        r = 5'($urandom_range(0, 15));
        if ($urandom_range(0, 9) < 7) begin
            for (int t = 0; t < 8; t++) begin
                if (m_busy[r[3:0]]) break;
                r = 5'($urandom_range(1, 15));
            end
        end
        return r;
    endfunction

    bit          pe_v, pl_v;
    logic [4:0]  pe_rd, pl_rd;
    logic [31:0] pe_d, pl_d;

    initial begin
        rst = 1;
        idle();
        @(negedge clk);
        do_reset();

        #1;
        chk("reset_rf_wen", rf_wen, 0);
        chk("reset_rf_waddr", rf_waddr, 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        chk("reset_wb_err", wb_err, 0);

        // Issue rd=5, EXU writes it back, dependent stalls until after the array write.
        issue_valid = 1; issue_rd = 5'd5; step();
        idle(); issue_rs1 = 5'd5; #1 chk("raw_stall_c2", issue_ready, 0); step();
        issue_rs1 = 5'd5; exu_wb_valid = 1; exu_wb_rd = 5'd5; exu_wb_data = 32'hDEADBEEF;
        #1 chk("raw_stall_c3", issue_ready, 0); chk("exu_gnt_c3", exu_wb_ready, 1); step();
        exu_wb_valid = 0;
        #1 chk("wr5_wen", rf_wen, 1); chk("wr5_addr", rf_waddr, 5); chk("wr5_data", rf_wdata, 32'hDEADBEEF);
        chk("raw_stall_c4", issue_ready, 0); step();
        #1 chk("raw_release_c5", issue_ready, 1); step();

        // Round-robin from reset: EXU first, then LSU.
        do_reset();
        issue_valid = 1; issue_rd = 5'd3; step();
        issue_rd = 5'd7; step();
        idle();
        exu_wb_valid = 1; exu_wb_rd = 5'd3; exu_wb_data = 32'h11;
        lsu_wb_valid = 1; lsu_wb_rd = 5'd7; lsu_wb_data = 32'h22;
        #1 chk("rr_c1_exu", exu_wb_ready, 1); chk("rr_c1_lsu", lsu_wb_ready, 0); step();
        #1 chk("rr_c2_lsu", lsu_wb_ready, 1); chk("rr_c2_exu", exu_wb_ready, 0);
        chk("rr_wr3_addr", rf_waddr, 3); chk("rr_wr3_data", rf_wdata, 32'h11); step();
        idle();
        #1 chk("rr_wr7_wen", rf_wen, 1); chk("rr_wr7_addr", rf_waddr, 7); chk("rr_wr7_data", rf_wdata, 32'h22);
        step();
        step();

        // x0 is never busy and writes to it are dropped.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
            #1 chk("x0_issue_ready", issue_ready, 1); step();
        end
        idle(); issue_valid = 1; issue_rs1 = 5'd9; issue_rd = 5'd12;
        exu_wb_valid = 1; exu_wb_rd = '0; exu_wb_data = 32'h55;
        #1 chk("x0_all_free", issue_ready, 1); step();
        idle();
        #1 chk("x0_no_wen", rf_wen, 0); chk("x0_no_err", wb_err, 0); step();

        // Writeback to a non-busy register flags a sticky error.
        do_reset();
        lsu_wb_valid = 1; lsu_wb_rd = 5'd9; lsu_wb_data = 32'h99; step();
        idle();
        #1 chk("err_wen", rf_wen, 1); chk("err_addr", rf_waddr, 9); chk("err_set", wb_err, 1); step();
        for (int i = 0; i < 4; i++) step();
        chk("err_sticky", wb_err, 1);
        do_reset();
        #1 chk("err_cleared", wb_err, 0);

        // Flush clears the scoreboard.
        issue_valid = 1; issue_rd = 5'd2; step();
        issue_rd = 5'd4; step();
        issue_rs1 = 5'd2; issue_rd = 5'd4; flush = 1;
        #1 chk("flush_blocks", issue_ready, 0); step();
        flush = 0;
        #1 chk("after_flush", issue_ready, 1); step();
        idle(); step();

        // Reset right after an accept suppresses the array write.
        do_reset();
        issue_valid = 1; issue_rd = 5'd6; step();
        idle(); exu_wb_valid = 1; exu_wb_rd = 5'd6; exu_wb_data = 32'h66; step();
        rst = 1; lsu_wb_valid = 1; lsu_wb_rd = 5'd1; issue_valid = 1; issue_rs1 = 5'd6;
        #1 chk("rst_wen", rf_wen, 0); chk("rst_exu_rdy", exu_wb_ready, 0);
        chk("rst_lsu_rdy", lsu_wb_ready, 0); chk("rst_issue_rdy", issue_ready, 0); step();
        rst = 0; idle(); issue_valid = 1; issue_rs1 = 5'd6;
        #1 chk("post_rst_wen", rf_wen, 0); chk("post_rst_busy6", issue_ready, 1); step();

        // Randomized traffic with producers that hold their item until granted.
        idle();
        pe_v = 0; pl_v = 0; last_ge = 0; last_gl = 0;
        pe_rd = '0; pl_rd = '0; pe_d = '0; pl_d = '0;
        for (int c = 0; c < 4000; c++) begin
            if (last_ge) pe_v = 0;
            if (last_gl) pl_v = 0;
            if (!pe_v && $urandom_range(0, 99) < 55) begin
                pe_v = 1; pe_rd = pick_rd(); pe_d = $urandom;
            end
            if (!pl_v && $urandom_range(0, 99) < 55) begin
                pl_v = 1; pl_rd = pick_rd(); pl_d = $urandom;
            end
            exu_wb_valid = pe_v; exu_wb_rd = pe_rd; exu_wb_data = pe_d;
            lsu_wb_valid = pl_v; lsu_wb_rd = pl_rd; lsu_wb_data = pl_d;
            issue_valid = ($urandom_range(0, 99) < 70);
            issue_rs1 = 5'($urandom_range(0, 31));
            issue_rs2 = 5'($urandom_range(0, 31));
            issue_rd  = 5'($urandom_range(0, 31));
            flush = ($urandom_range(0, 99) < 3);
            rst   = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0;
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
